// File: rtl/sseg_scan_if.sv
// Bundle between the command/UART writer and the seven-segment scan controller.
// The writer drives the i_* side and the scan controller drives the o_* side.
interface sseg_scan_if #(
  parameter int NUM_DIGITS = 4
);
  logic                  i_enable;
  logic                  i_wr_en;
  logic [2:0]            i_wr_addr;
  logic [3:0]            i_wr_data;
  logic                  i_commit;
  logic                  i_lz_en;
  logic [3:0]            o_bin;
  logic [NUM_DIGITS-1:0] o_digit_en;
  logic                  o_commit_ack;
  logic                  o_frame_tick;

  modport master (
    output i_enable, i_wr_en, i_wr_addr, i_wr_data, i_commit, i_lz_en,
    input  o_bin, o_digit_en, o_commit_ack, o_frame_tick
  );

  modport slave (
    input  i_enable, i_wr_en, i_wr_addr, i_wr_data, i_commit, i_lz_en,
    output o_bin, o_digit_en, o_commit_ack, o_frame_tick
  );
endinterface

// File: rtl/sseg_scan_ctrl.sv
// Scan controller: multiplexes double-buffered nibbles onto one shared seven-seg decoder.
// Latency: outputs registered one cycle after the scan decision; frame = NUM_DIGITS*(BLANK+DWELL) cycles.
// Backpressure: none; writes/commits accepted every cycle, shadow->active copy deferred to frame end.
module sseg_scan_ctrl #(
  parameter int NUM_DIGITS   = 4,
  parameter int DWELL_CYCLES = 50000,
  parameter int BLANK_CYCLES = 500
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  sseg_scan_if.slave bus
);
  localparam int IDX_W   = $clog2(NUM_DIGITS);
  localparam int MAX_CYC = (DWELL_CYCLES > BLANK_CYCLES) ? DWELL_CYCLES : BLANK_CYCLES;
  localparam int CNT_W   = $clog2(MAX_CYC + 1);
  localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(NUM_DIGITS - 1);
  localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);
  localparam logic [CNT_W-1:0] DWELL_LAST = CNT_W'(DWELL_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, BLANK, DRIVE} state_t;

  state_t                state, state_nxt;
  logic [IDX_W-1:0]      idx, idx_nxt;
  logic [CNT_W-1:0]      cnt, cnt_nxt;
  logic                  frame_end;
  logic                  copy;
  logic                  pending;
  logic                  wr_hit;
  logic                  zero_above;
  logic [NUM_DIGITS-1:0] suppress;
  logic [3:0]            shadow [NUM_DIGITS];
  logic [3:0]            active [NUM_DIGITS];
  logic [3:0]            bin_q, bin_nxt;
  logic [NUM_DIGITS-1:0] digit_en_q, digit_en_nxt;
  logic                  commit_ack_q, frame_tick_q;

  assign wr_hit = bus.i_wr_en && ({1'b0, bus.i_wr_addr} < 4'(NUM_DIGITS));
  assign copy   = frame_end && pending;

  // A digit is blanked when it and every more-significant digit are zero.
  always_comb begin
    zero_above = 1'b1;
    suppress   = '0;
    for (int k = NUM_DIGITS - 1; k >= 1; k--) begin
      zero_above  = zero_above && (active[k] == 4'd0);
      suppress[k] = bus.i_lz_en && zero_above;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state <= IDLE;
      idx   <= '0;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      idx   <= idx_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    cnt_nxt   = cnt;
    frame_end = 1'b0;
    if (!bus.i_enable) begin
      state_nxt = IDLE;
      idx_nxt   = '0;
      cnt_nxt   = '0;
    end else begin
      case (state)
        IDLE: begin
          state_nxt = BLANK;
          idx_nxt   = '0;
          cnt_nxt   = '0;
        end
        BLANK: begin
          if (cnt == BLANK_LAST) begin
            state_nxt = DRIVE;
            cnt_nxt   = '0;
          end else begin
            cnt_nxt = cnt + 1'b1;
          end
        end
        DRIVE: begin
          if (cnt == DWELL_LAST) begin
            state_nxt = BLANK;
            cnt_nxt   = '0;
            if (idx == LAST_IDX) begin
              idx_nxt   = '0;
              frame_end = 1'b1;
            end else begin
              idx_nxt = idx + 1'b1;
            end
          end else begin
            cnt_nxt = cnt + 1'b1;
          end
        end
        default: begin
          state_nxt = IDLE;
          idx_nxt   = '0;
          cnt_nxt   = '0;
        end
      endcase
    end
  end

  // o_bin is loaded on BLANK entry; at a copying frame end the new digit 0 comes straight from shadow.
  always_comb begin
    bin_nxt = bin_q;
    if (state_nxt == BLANK && state != BLANK)
      bin_nxt = copy ? shadow[0] : active[idx_nxt];
    digit_en_nxt = '0;
    if (state_nxt == DRIVE && !suppress[idx_nxt])
      digit_en_nxt = NUM_DIGITS'(1) << idx_nxt;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      bin_q        <= '0;
      digit_en_q   <= '0;
      commit_ack_q <= 1'b0;
      frame_tick_q <= 1'b0;
      pending      <= 1'b0;
    end else begin
      bin_q        <= bin_nxt;
      digit_en_q   <= digit_en_nxt;
      commit_ack_q <= copy;
      frame_tick_q <= frame_end;
      // A commit landing on the copying edge belongs to the next frame.
      if (copy)
        pending <= bus.i_commit;
      else if (bus.i_commit)
        pending <= 1'b1;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int k = 0; k < NUM_DIGITS; k++) begin
        shadow[k] <= '0;
        active[k] <= '0;
      end
    end else begin
      if (copy) begin
        for (int k = 0; k < NUM_DIGITS; k++)
          active[k] <= shadow[k];
      end
      if (wr_hit)
        shadow[bus.i_wr_addr[IDX_W-1:0]] <= bus.i_wr_data;
    end
  end

  assign bus.o_bin        = bin_q;
  assign bus.o_digit_en   = digit_en_q;
  assign bus.o_commit_ack = commit_ack_q;
  assign bus.o_frame_tick = frame_tick_q;
endmodule

// File: doc/sseg_scan_ctrl.md
Name: sseg_scan_ctrl

Overview:
- Time-multiplexed scan controller for a bank of common-cathode seven-segment digits sharing one seven_seg decoder.
- Holds a double-buffered 4-bit value per digit and sequences digits with a dwell and a dead-time gap to prevent ghosting.
- Drives the shared decoder input (o_bin) and one-hot digit enables.
- Sits between the UART receive/command logic (writer) and the display pins.

Parameters:
- NUM_DIGITS, 4, number of digits; legal range 2..8; digit 0 is least significant.
- DWELL_CYCLES, 50000, clocks a digit stays enabled; must be >= 1.
- BLANK_CYCLES, 500, dead-time clocks with all digits off between digits; must be >= 1.

Ports:
- i_clk  in  1  system clock
- i_rst_n  in  1  asynchronous active-low reset
- i_enable  in  1  scanning on when high
- i_wr_en  in  1  write shadow digit this cycle
- i_wr_addr  in  3  shadow digit index
- i_wr_data  in  4  nibble to write
- i_commit  in  1  request shadow-to-active copy at next frame end (pulse)
- i_lz_en  in  1  leading-zero suppression enable
- o_bin  out  4  value to the shared seven_seg decoder
- o_digit_en  out  NUM_DIGITS  one-hot digit enable, active-high
- o_commit_ack  out  1  one-cycle pulse when a copy occurs
- o_frame_tick  out  1  one-cycle pulse at every frame end

Behaviour:
- Reset (async assert, sync release):
  - State IDLE, digit index 0, counter 0, commit-pending 0.
  - Shadow and active arrays all 0.
  - All outputs 0.
- All outputs are registered.
- Index width is $clog2(NUM_DIGITS). Counter width covers max(DWELL_CYCLES, BLANK_CYCLES).
- FSM states and transitions:
  - IDLE: o_digit_en=0. When i_enable=1, go to BLANK with index 0 and counter 0.
  - BLANK: o_digit_en=0. o_bin is updated to active[index] on entry. After BLANK_CYCLES cycles, go to DRIVE.
  - DRIVE: o_digit_en=1<<index, unless the digit is suppressed. After DWELL_CYCLES cycles, go to BLANK with index+1.
  - Wrap: the index goes from NUM_DIGITS-1 back to 0.
- Frame end is the DRIVE->BLANK transition out of index NUM_DIGITS-1. On that edge:
  - o_frame_tick=1 for one cycle.
  - If commit-pending=1: copy shadow to active, clear pending, and set o_commit_ack=1 for one cycle.
  - i_commit or i_wr_en asserted in that same cycle is not included in the copy. It takes effect in the shadow/pending state for the next frame.
- Writes:
  - i_wr_en with i_wr_addr < NUM_DIGITS writes shadow[i_wr_addr] at the clock edge.
  - Out-of-range addresses are ignored.
  - Writes never alter active digits directly, so there is no tearing.
- i_commit sets commit-pending. Repeated commits before frame end merge into a single copy and a single ack.
- Leading-zero suppression (i_lz_en=1):
  - Digit k>0 is suppressed if active[k]==0 and every active[j] for j>k is 0.
  - Digit 0 is never suppressed.
  - A suppressed digit keeps full slot timing with o_digit_en=0.
- i_enable deasserted in any state:
  - Next cycle enters IDLE with o_digit_en=0, index 0, counter 0.
  - No frame tick or ack is generated.
  - Shadow, active and commit-pending are retained.
- Reset mid-frame clears everything, including any pending commit.
- At most one o_digit_en bit is high in any cycle, and never in BLANK or IDLE.

Test Plan:
Common setup: NUM_DIGITS=4, DWELL_CYCLES=4, BLANK_CYCLES=2, so a frame is 24 cycles.
- Reset then i_enable=1 with all digits 0 -> 2 cycles all-off, then o_digit_en=0001 for 4 cycles, 2 off, 0010 for 4 cycles, and so on. o_frame_tick pulses every 24 cycles. o_bin=0 throughout.
- Write shadow {3:0x4, 2:0x3, 1:0x2, 0:0x1}, then pulse i_commit mid-frame -> active unchanged until frame end. o_commit_ack pulses once with o_frame_tick. The next frame shows o_bin=1,2,3,4 during enables 0001,0010,0100,1000.
- i_commit asserted in the exact frame-end cycle -> no ack at that tick; ack occurs at the following frame end.
- i_lz_en=1 with active {0,0,0x5,0} -> enables 0001 and 0010 pulse, slots for digits 2 and 3 stay off, and the frame length stays 24 cycles. active all 0 -> only 0001 is lit.
- Drop i_enable during the DRIVE of digit 2 -> o_digit_en=0 next cycle, no tick. Re-enable -> the scan restarts at digit 0 and prior active values are kept.
- Assert i_rst_n=0 with a commit pending -> all outputs are 0 immediately (async). After release, no ack ever appears without a new i_commit. A write to i_wr_addr=5 has no effect.
